// File: rtl/uart_tx_buffer.sv
// Word FIFO feeding a byte-level UART transmitter: each 32-bit word is sent as
// four bytes, least-significant byte first, through a start/busy/done handshake.
module uart_tx_buffer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      tx_float,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [7:0]       tx_byte,
   output logic             tx_start,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic             word_done,
   output logic             tx_active,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_WAIT
   } state_t;

   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [31:0]      shift_q, shift_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             tx_start_q, tx_start_d;
   logic             word_done_q, word_done_d;
   logic             push;
   logic             pop;

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign push = tx_load && (count_q != FULL);
   assign pop  = (state_q == S_IDLE) && (count_q != '0);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      tx_byte_d   = tx_byte_q;
      tx_start_d  = 1'b0;
      word_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               idx_d   = 2'd0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            // Byte and start are registered together so uart_tx sees a stable byte with the pulse.
            tx_byte_d = shift_q[7:0];
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tx_done) begin
               if (idx_q == 2'd3) begin
                  word_done_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  shift_d = {8'h00, shift_q[31:8]};
                  idx_d   = idx_q + 2'd1;
                  state_d = S_ARM;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         idx_q       <= 2'd0;
         shift_q     <= '0;
         tx_byte_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         tx_byte_q   <= tx_byte_d;
         tx_start_q  <= tx_start_d;
         word_done_q <= word_done_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_float;
      end
   end

   assign tx_ready   = (count_q != FULL);
   assign tx_byte    = tx_byte_q;
   assign tx_start   = tx_start_q;
   assign word_done  = word_done_q;
   assign tx_active  = (state_q != S_IDLE);
   assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a behavioural uart_tx responder that
// logs every byte launched by a tx_start pulse.
module tb_uart_tx_buffer;

   logic        clk;
   logic        reset;
   logic [31:0] tx_float;
   logic        tx_load;
   logic        tx_ready;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_busy;
   logic        tx_done;
   logic        word_done;
   logic        tx_active;
   logic [2:0]  fifo_count;

   logic        model_busy, model_done, force_busy, hold_done;
   logic [7:0]  byte_log[$];
   int          start_cnt, wd_cnt, done_cnt, busy_starts;
   int          vectors, miscompares;

   assign tx_busy = model_busy | force_busy;
   assign tx_done = model_done;

   uart_tx_buffer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .tx_float(tx_float), .tx_load(tx_load),
      .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .word_done(word_done),
      .tx_active(tx_active), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural uart_tx: busy from the start pulse, tx_done 10 cycles later.
   initial begin
      int  cnt;
      bit  inflight;
      cnt = 0;
      inflight = 0;
      model_busy = 1'b0;
      model_done = 1'b0;
      forever begin
         @(negedge clk);
         if (model_done) model_done = 1'b0;
         if (inflight) begin
            if (cnt > 1) cnt--;
            else if (!hold_done) begin
               model_done = 1'b1;
               model_busy = 1'b0;
               inflight   = 0;
               done_cnt++;
            end
         end
         if (tx_start === 1'b1) begin
            if (tx_busy !== 1'b0) busy_starts++;
            byte_log.push_back(tx_byte);
            start_cnt++;
            $display("byte %0d sent: 0x%02h at %0t", start_cnt, tx_byte, $time);
            inflight   = 1;
            model_busy = 1'b1;
            cnt        = 10;
         end
         if (word_done === 1'b1) wd_cnt++;
      end
   end

   task automatic clear_log();
      byte_log.delete();
      start_cnt = 0;
      wd_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic push_word(input logic [31:0] w);
      tx_float = w;
      tx_load  = 1'b1;
      @(negedge clk);
      tx_load  = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_active === 1'b0 && fifo_count === 3'd0) begin
            ok = 1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if (tx_ready !== 1'b1 || tx_byte !== 8'h00 || tx_start !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_handshake: ready=%b byte=%02h start=%b, required 1/00/0",
                  tag, tx_ready, tx_byte, tx_start);
      end
      vectors++;
      if (word_done !== 1'b0 || tx_active !== 1'b0 || fifo_count !== 3'd0) begin
         miscompares++;
         $display("FAIL %s_status: word_done=%b active=%b count=%0d, required 0/0/0",
                  tag, word_done, tx_active, fifo_count);
      end
   endtask

   task automatic check_bytes(input string tag, input logic [31:0] words[$]);
      logic [7:0] exp_b;
      vectors++;
      if (byte_log.size() != words.size() * 4) begin
         miscompares++;
         $display("FAIL %s_nbytes: got %0d bytes, required %0d", tag, byte_log.size(), words.size() * 4);
      end else begin
         for (int i = 0; i < byte_log.size(); i++) begin
            exp_b = 8'(words[i / 4] >> (8 * (i % 4)));
            vectors++;
            if (byte_log[i] !== exp_b) begin
               miscompares++;
               $display("FAIL %s_byte%0d: got 0x%02h, required 0x%02h", tag, i, byte_log[i], exp_b);
            end
         end
      end
      vectors++;
      if (start_cnt != words.size() * 4 || wd_cnt != words.size()) begin
         miscompares++;
         $display("FAIL %s_counts: starts=%0d word_done=%0d, required %0d/%0d",
                  tag, start_cnt, wd_cnt, words.size() * 4, words.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tx_load = 1'b1;
      tx_float = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      tx_load = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      clear_log();
   endtask

   task automatic test_single_word();
      bit ok;
      clear_log();
      push_word(32'h3F80_0000);
      vectors++;
      if (fifo_count !== 3'd1 || tx_active !== 1'b0) begin
         miscompares++;
         $display("FAIL single_after_push: count=%0d active=%b, required 1/0", fifo_count, tx_active);
      end
      @(negedge clk);
      vectors++;
      if (tx_active !== 1'b1 || fifo_count !== 3'd0 || tx_start !== 1'b0) begin
         miscompares++;
         $display("FAIL single_after_pop: active=%b count=%0d start=%b, required 1/0/0",
                  tx_active, fifo_count, tx_start);
      end
      @(negedge clk);
      vectors++;
      if (tx_start !== 1'b1 || tx_byte !== 8'h00) begin
         miscompares++;
         $display("FAIL single_first_start: start=%b byte=%02h, required 1/00", tx_start, tx_byte);
      end
      wait_idle(300, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL single_timeout: active=%b, required 0", tx_active);
      end
      check_bytes("single", '{32'h3F80_0000});
   endtask

   task automatic test_fill_overflow();
      bit ok;
      clear_log();
      hold_done = 1'b1;
      push_word(32'h1111_1111);
      push_word(32'h2222_2222);
      push_word(32'h3333_3333);
      push_word(32'h4444_4444);
      push_word(32'h5555_5555);
      vectors++;
      if (tx_ready !== 1'b0 || fifo_count !== 3'd4) begin
         miscompares++;
         $display("FAIL fill_full: ready=%b count=%0d, required 0/4", tx_ready, fifo_count);
      end
      push_word(32'h6666_6666);
      vectors++;
      if (tx_ready !== 1'b0 || fifo_count !== 3'd4) begin
         miscompares++;
         $display("FAIL fill_overflow: ready=%b count=%0d, required 0/4", tx_ready, fifo_count);
      end
      repeat (5) @(negedge clk);
      hold_done = 1'b0;
      wait_idle(1500, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL fill_timeout: active=%b count=%0d, required 0/0", tx_active, fifo_count);
      end
      check_bytes("fill", '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555});
   endtask

   task automatic test_busy_stall();
      bit ok;
      int early;
      clear_log();
      force_busy = 1'b1;
      push_word(32'hA1B2_C3D4);
      early = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_start !== 1'b0) early++;
      end
      vectors++;
      if (early != 0 || tx_byte !== 8'hD4 || tx_active !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_hold: early_starts=%0d byte=%02h active=%b, required 0/d4/1",
                  early, tx_byte, tx_active);
      end
      force_busy = 1'b0;
      @(negedge clk);
      vectors++;
      if (tx_start !== 1'b1 || tx_byte !== 8'hD4) begin
         miscompares++;
         $display("FAIL busy_release: start=%b byte=%02h, required 1/d4", tx_start, tx_byte);
      end
      wait_idle(300, ok);
      vectors++;
      if (!ok || busy_starts != 0) begin
         miscompares++;
         $display("FAIL busy_finish: idle=%0d starts_while_busy=%0d, required 1/0", ok, busy_starts);
      end
      check_bytes("busy", '{32'hA1B2_C3D4});
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [31:0] got;
      logic [31:0] exp_w[2];
      exp_w[0] = 32'h4049_0FDB;
      exp_w[1] = 32'hC2C8_0000;
      clear_log();
      push_word(exp_w[0]);
      push_word(exp_w[1]);
      wait_idle(500, ok);
      vectors++;
      if (!ok || byte_log.size() != 8) begin
         miscompares++;
         $display("FAIL loop_len: idle=%0d bytes=%0d, required 1/8", ok, byte_log.size());
      end else begin
         for (int w = 0; w < 2; w++) begin
            got = {byte_log[4*w+3], byte_log[4*w+2], byte_log[4*w+1], byte_log[4*w]};
            vectors++;
            if (got !== exp_w[w]) begin
               miscompares++;
               $display("FAIL loop_word%0d: got 0x%08h, required 0x%08h", w, got, exp_w[w]);
            end
         end
      end
      vectors++;
      if (wd_cnt != 2) begin
         miscompares++;
         $display("FAIL loop_word_done: got %0d pulses, required 2", wd_cnt);
      end
   endtask

   task automatic test_reset_mid_word();
      bit ok;
      int n;
      clear_log();
      push_word(32'h0102_0304);
      push_word(32'h0506_0708);
      push_word(32'h090A_0B0C);
      vectors++;
      if (fifo_count !== 3'd2) begin
         miscompares++;
         $display("FAIL midrst_queued: count=%0d, required 2", fifo_count);
      end
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_cnt >= 2) begin
            ok = 1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL midrst_timeout: done_cnt=%0d, required 2", done_cnt);
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_reset_outputs("midrst");
      n = start_cnt;
      repeat (40) @(negedge clk);
      vectors++;
      if (start_cnt != n || fifo_count !== 3'd0 || tx_active !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_quiet: starts %0d->%0d count=%0d active=%b, required no change/0/0",
                  n, start_cnt, fifo_count, tx_active);
      end
      clear_log();
      push_word(32'hDEAD_BEEF);
      wait_idle(300, ok);
      check_bytes("midrst_new", '{32'hDEAD_BEEF});
   endtask

   task automatic test_simul_push_pop();
      bit ok;
      clear_log();
      push_word(32'h0A0B_0C0D);
      repeat (3) @(negedge clk);
      push_word(32'h1A1B_1C1D);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_active === 1'b0 && fifo_count === 3'd1) begin
            ok = 1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL simul_wait: active=%b count=%0d, required 0/1", tx_active, fifo_count);
      end
      push_word(32'h2A2B_2C2D);
      vectors++;
      if (fifo_count !== 3'd1 || tx_active !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_count: count=%0d active=%b, required 1/1", fifo_count, tx_active);
      end
      wait_idle(600, ok);
      check_bytes("simul", '{32'h0A0B_0C0D, 32'h1A1B_1C1D, 32'h2A2B_2C2D});
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      busy_starts = 0;
      force_busy = 1'b0;
      hold_done = 1'b0;
      tx_load = 1'b0;
      tx_float = '0;
      reset = 1'b0;
      clear_log();
      @(negedge clk);
      test_reset();
      test_single_word();
      test_fill_overflow();
      test_busy_stall();
      test_back_to_back();
      test_reset_mid_word();
      test_simul_push_pop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Transmit-side counterpart of the UART receive word assembler. It accepts 32-bit words (IEEE-754 floats) from the datapath into a small FIFO. Each word is serialised into 4 bytes, least-significant byte first, and driven to the byte-level uart_tx core through a start/busy/done handshake. The byte order matches the receive assembler, so a TX→RX loopback reproduces the original word.

Parameters:
FIFO_DEPTH, 4, number of 32-bit words buffered; power of two, ≥2.
CNT_W, 3, width of the occupancy counter; must equal log2(FIFO_DEPTH)+1.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
tx_float  input  32  word to transmit
tx_load  input  1  push strobe; tx_float is captured when tx_load=1 and tx_ready=1
tx_ready  output  1  1 when the FIFO can accept a word (count < FIFO_DEPTH)
tx_byte  output  8  byte presented to uart_tx
tx_start  output  1  one-cycle start pulse to uart_tx
tx_busy  input  1  uart_tx is shifting a frame
tx_done  input  1  one-cycle pulse from uart_tx at the end of a frame
word_done  output  1  one-cycle pulse after byte 3 of a word completes
tx_active  output  1  1 whenever the FSM is not in IDLE
fifo_count  output  CNT_W  current FIFO occupancy

Behaviour:
- Reset (reset=0 at a clk edge): FIFO empty, rd/wr pointers 0, fifo_count=0, tx_ready=1, tx_byte=0x00, tx_start=0, word_done=0, tx_active=0, FSM=IDLE, byte index=0, shift register=0. Reset mid-word abandons that word and flushes the FIFO. The byte already in flight in uart_tx is not recalled.
- Push: on an edge where tx_load=1 and tx_ready=1, write tx_float at wr_ptr, increment wr_ptr (wraps mod FIFO_DEPTH), fifo_count+1. A tx_load while tx_ready=0 is ignored; no error flag is raised.
- tx_ready is combinational: (fifo_count != FIFO_DEPTH).
- Simultaneous push and pop in one cycle: fifo_count is unchanged and both pointers advance. When full, a push is refused even if a pop occurs in that cycle.
- FSM states:
  - IDLE: if fifo_count≠0, pop the head word into the 32-bit shift register, set byte index=0, go to ARM. Otherwise stay.
  - ARM: tx_byte = shift[7:0]. If tx_busy=0, assert tx_start for exactly this one cycle and go to WAIT. If tx_busy=1, hold in ARM with tx_start=0.
  - WAIT: hold tx_byte stable. On tx_done=1:
    - byte index<3: shift register >>8, index+1, go to ARM.
    - byte index=3: pulse word_done=1 in the next cycle, go to IDLE.
- Back-to-back words: IDLE re-pops in the cycle after word_done if the FIFO is non-empty. Inter-word gap is 2 clk cycles beyond uart_tx's own timing.
- Latency: push at edge N into an empty FIFO while IDLE:
  - pop at edge N+1
  - tx_start=1 during cycle N+2 (tx_busy=0)
  - tx_byte = tx_float[7:0] from edge N+2.
- Byte sequence per word: [7:0], [15:8], [23:16], [31:24].
- tx_done arriving outside WAIT is ignored.
- tx_start is never asserted while tx_busy=1.
- Exactly 4 tx_start pulses per popped word.
- tx_active=1 in ARM and WAIT.
- fifo_count counts only words not yet popped. The word in the shift register is not included.

Test Plan:
- Single word: push 0x3F800000 with tx_busy=0 and tx_done returned 10 cycles after each tx_start → tx_byte sequence 0x00, 0x00, 0x80, 0x3F; 4 tx_start pulses; one word_done; tx_active returns to 0.
- Fill/overflow: hold tx_done low and push 0x11111111..0x66666666 on consecutive cycles → first word popped; fifo_count reaches 4 with 0x22222222..0x55555555 buffered; tx_ready=0; 0x66666666 dropped. Then release tx_done → four more words sent in order, no 0x66 bytes.
- Busy stall: tx_busy=1 for 20 cycles after the pop → tx_start stays 0 and tx_byte stays at byte 0. tx_start fires in the first cycle tx_busy=0.
- Loopback: connect to uart_tx/uart_rx/uart_rx_buffer and send 0x40490FDB, 0xC2C80000 → rx_float matches each word, one rx_valid per word.
- Reset mid-word: assert reset=0 for 1 cycle after byte 1's tx_done with 2 words queued → all outputs at reset values, fifo_count=0. No further tx_start until a new push.
- Simultaneous push/pop: FIFO holds 1 word, IDLE, push in the pop cycle → fifo_count stays 1 and the pushed word is transmitted next.
